bar_counter_ctrl: RTL and testbench
===================================

Name: bar_counter_ctrl

Overview:
Parametrised successor to the two-button LED bar counter. Takes raw active-low up/down/clear buttons and runs each through a 2-FF synchroniser and a debounce filter. Adds hold-to-repeat auto-increment, selectable saturate/wrap arithmetic, and selectable bar or binary LED display. Sits between the board push-buttons and the LED bank on the lesson top level.

Parameters:
N_LEDS, 8, number of LED outputs; the counter range is 0..N_LEDS.
CNT_W, 4, count register width; must satisfy 2^CNT_W > N_LEDS.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change (>=1).
REPEAT_DELAY, 16, held cycles after acceptance before the first auto-repeat; 0 disables repeat.
REPEAT_RATE, 4, cycles between subsequent auto-repeats (>=1).
SATURATE, 1, 1 = clamp at 0 and N_LEDS; 0 = wrap modulo N_LEDS+1.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
w_button_up  input  1  raw up button, active-low (pressed = 0)
w_button_down  input  1  raw down button, active-low
w_button_clr  input  1  raw clear button, active-low
mode  input  1  display mode: 0 = bar, 1 = binary
diod  output  N_LEDS  LED drive
count  output  CNT_W  current counter value
at_max  output  1  count == N_LEDS
at_min  output  1  count == 0

Behaviour:
- Reset: every register is cleared while reset == 0 at a rising edge. This covers synchronisers, debounce counters, accepted-button states (released), hold/repeat counters and count. Outputs after reset: count = 0, at_min = 1, at_max = 0, diod = 0 in both modes.
- Per button, synchronise: s1 <= ~w_button_x; s2 <= s1. Value 1 means pressed.
- Per button, debounce:
  - The counter increments each edge that s2 != accepted; it clears to 0 on any edge where s2 == accepted.
  - accepted flips on the edge where the counter would reach DEBOUNCE_CYCLES; the counter then clears.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles are ignored.
- Press event: a one-cycle pulse in the cycle after accepted goes 0->1.
- Latency: count changes on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the raw input low as edge 1.
- Auto-repeat (up/down only; clear never repeats):
  - The hold counter starts at 0 on acceptance and increments while accepted = 1, saturating at its max.
  - Extra events fire when hold == REPEAT_DELAY, and every REPEAT_RATE cycles after that.
  - Release (accepted -> 0) clears the hold counter immediately. No event is generated on release.
- Event arbitration, per cycle:
  - clear event -> count <= 0, overriding everything.
  - Up and down events in the same cycle -> no change.
  - Up alone -> increment; down alone -> decrement.
- Arithmetic:
  - SATURATE = 1: up at N_LEDS holds N_LEDS; down at 0 holds 0.
  - SATURATE = 0: up at N_LEDS -> 0; down at 0 -> N_LEDS.
  - count is never outside 0..N_LEDS.
- Display, combinational from count and mode:
  - Bar mode: diod[i] = (i < count).
  - Binary mode: diod = count zero-extended, or truncated if CNT_W > N_LEDS.
  - A mode change takes effect in the same cycle and does not alter count.
- at_max and at_min are combinational from count.
- Reset mid-operation:
  - A button held through reset release is seen as a fresh press after the normal debounce latency.
  - No pending repeat survives reset.

Test Plan:
- Defaults; hold reset 0 for 3 cycles, then 1 -> count=0, diod=8'h00, at_min=1, at_max=0.
- Raw up low for 10 cycles, then high -> exactly one increment at edge 7 (count 0->1), diod=8'h01. A 3-cycle low glitch on up produces no change.
- Five separate up presses with SATURATE=1, then with SATURATE=0 -> 1,2,3,4,5. Starting from count=8, one more up gives 8 (saturate) vs 0 (wrap). A down from 0 gives 0 vs 8.
- REPEAT_DELAY=16, REPEAT_RATE=4; hold up for 40 cycles from count=0 -> count=1 at edge 7, 2 at edge 23, then +1 every 4 edges (3 at 27, 4 at 31, 5 at 35, 6 at 39). No change after release.
- Up and down pressed together, aligned -> count unchanged. Clear pressed together with up at count=5 -> count=0. Clear held for 40 cycles -> remains 0, no repeat effect.
- count=5: mode=0 -> diod=8'h1F; mode=1 -> diod=8'h05; count stays 5. Assert reset during an active up repeat -> count=0 next edge, and a continued hold yields a new press 7 edges after reset release.

Source files
------------

// File: rtl/bar_counter_ctrl.sv
// Debounced up/down/clear push-button counter with hold-to-repeat, saturate or
// wrap arithmetic, and a bar or binary LED display.
module bar_counter_ctrl #(
  parameter int N_LEDS          = 8,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int SATURATE        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_button_up,
  input  logic              w_button_down,
  input  logic              w_button_clr,
  input  logic              mode,
  output logic [N_LEDS-1:0] diod,
  output logic [CNT_W-1:0]  count,
  output logic              at_max,
  output logic              at_min
);

  localparam int NB     = 3;  // 0 = up, 1 = down, 2 = clear
  localparam int NR     = 2;  // only up and down auto-repeat
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 2);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(N_LEDS);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_DELAY);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(REPEAT_RATE - 1);

  logic [NB-1:0]     s1, s2, acc, acc_d;
  logic [DB_W-1:0]   db_cnt [NB];
  logic [HOLD_W-1:0] hold   [NR];
  logic [RATE_W-1:0] rate   [NR];

  logic [NB-1:0]    press;
  logic [NR-1:0]    rpt;
  logic             ev_up, ev_dn, ev_clr;
  logic [CNT_W-1:0] count_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      acc   <= '0;
      acc_d <= '0;
      for (int unsigned b = 0; b < NB; b++) db_cnt[b] <= '0;
      for (int unsigned b = 0; b < NR; b++) begin
        hold[b] <= '0;
        rate[b] <= '0;
      end
      count <= '0;
    end else begin
      s1    <= ~{w_button_clr, w_button_down, w_button_up};
      s2    <= s1;
      acc_d <= acc;
      for (int unsigned b = 0; b < NB; b++) begin
        if (s2[b] == acc[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          acc[b]    <= ~acc[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
      // hold parks at REPEAT_DELAY; rate then paces the repeats from there
      for (int unsigned b = 0; b < NR; b++) begin
        if (!acc[b]) begin
          hold[b] <= '0;
          rate[b] <= '0;
        end else if (hold[b] != HOLD_MAX) begin
          hold[b] <= hold[b] + 1'b1;
        end else begin
          rate[b] <= (rate[b] == RATE_LAST) ? '0 : rate[b] + 1'b1;
        end
      end
      count <= count_nxt;
    end
  end

  always_comb begin
    press = acc & ~acc_d;
    for (int unsigned b = 0; b < NR; b++)
      rpt[b] = (REPEAT_DELAY != 0) && acc[b] && (hold[b] == HOLD_MAX) && (rate[b] == '0);
    ev_up  = press[0] | rpt[0];
    ev_dn  = press[1] | rpt[1];
    ev_clr = press[2];

    count_nxt = count;
    if (ev_clr) begin
      count_nxt = '0;
    end else if (ev_up && !ev_dn) begin
      if (count == CNT_MAX) count_nxt = (SATURATE != 0) ? CNT_MAX : '0;
      else                  count_nxt = count + 1'b1;
    end else if (ev_dn && !ev_up) begin
      if (count == '0) count_nxt = (SATURATE != 0) ? '0 : CNT_MAX;
      else             count_nxt = count - 1'b1;
    end
  end

  logic [N_LEDS+CNT_W-1:0] count_ext;

  always_comb begin
    count_ext = {{N_LEDS{1'b0}}, count};
    diod      = '0;
    if (mode) begin
      diod = count_ext[N_LEDS-1:0];
    end else begin
      for (int unsigned i = 0; i < N_LEDS; i++)
        diod[i] = (CNT_W'(i) < count);
    end
  end

  assign at_max = (count == CNT_MAX);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_bar_counter_ctrl.sv
// Scoreboard bench: saturating and wrapping instances share the button inputs
// and are checked every cycle against a behavioural model.
module tb_bar_counter_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;

  logic clk = 1'b0;
  logic reset, w_button_up, w_button_down, w_button_clr, mode;
  logic [N-1:0]  diod_s, diod_w;
  logic [CW-1:0] count_s, count_w;
  logic          at_max_s, at_min_s, at_max_w, at_min_w;

  always #5 clk = ~clk;

  bar_counter_ctrl #(.N_LEDS(N), .CNT_W(CW), .DEBOUNCE_CYCLES(DB),
                     .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .w_button_up(w_button_up), .w_button_down(w_button_down),
    .w_button_clr(w_button_clr), .mode(mode), .diod(diod_s), .count(count_s),
    .at_max(at_max_s), .at_min(at_min_s));

  bar_counter_ctrl #(.N_LEDS(N), .CNT_W(CW), .DEBOUNCE_CYCLES(DB),
                     .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .w_button_up(w_button_up), .w_button_down(w_button_down),
    .w_button_clr(w_button_clr), .mode(mode), .diod(diod_w), .count(count_w),
    .at_max(at_max_w), .at_min(at_min_w));

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [N-1:0]  led;
    logic          mx;
    logic          mn;
  } resp_t;

  typedef struct packed {
    resp_t s;
    resp_t w;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: pressed levels delayed two cycles, a run-length debounce,
  // and a plain count of held cycles since acceptance for the repeat schedule.
  int m_s1[3], m_s2[3], m_acc[3], m_prev[3], m_run[3], m_held[3];
  int m_cnt_s, m_cnt_w;

  function automatic logic [N-1:0] leds(input int c, input logic md);
    logic [N-1:0] d;
    d = '0;
    if (md) d = N'(c);
    else for (int i = 0; i < N; i++) d[i] = (i < c);
    return d;
  endfunction

  function automatic resp_t mk(input int c, input logic md);
    resp_t r;
    r.cnt = CW'(c);
    r.led = leds(c, md);
    r.mx  = (c == N);
    r.mn  = (c == 0);
    return r;
  endfunction

  task automatic model_edge(input logic rst_n, input int up, input int dn, input int cl);
    int  pressed[3];
    bit  ev[3];
    pressed[0] = up; pressed[1] = dn; pressed[2] = cl;
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_prev[b] = 0; m_run[b] = 0; m_held[b] = 0;
      end
      m_cnt_s = 0;
      m_cnt_w = 0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = (m_acc[b] == 1) && (m_prev[b] == 0);
      if (b < 2 && RD != 0 && m_acc[b] == 1 && m_held[b] >= RD && ((m_held[b] - RD) % RR) == 0)
        ev[b] = 1'b1;
    end
    if (ev[2]) begin
      m_cnt_s = 0;
      m_cnt_w = 0;
    end else if (ev[0] && !ev[1]) begin
      m_cnt_s = (m_cnt_s + 1 > N) ? N : m_cnt_s + 1;
      m_cnt_w = (m_cnt_w + 1) % (N + 1);
    end else if (ev[1] && !ev[0]) begin
      m_cnt_s = (m_cnt_s - 1 < 0) ? 0 : m_cnt_s - 1;
      m_cnt_w = (m_cnt_w + N) % (N + 1);
    end
    for (int b = 0; b < 3; b++) begin
      m_held[b] = (m_acc[b] == 1) ? m_held[b] + 1 : 0;
      m_prev[b] = m_acc[b];
      if (m_s2[b] == m_acc[b]) begin
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_acc[b] = 1 - m_acc[b];
          m_run[b] = 0;
        end
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = pressed[b];
    end
  endtask

  // One clock: drive at the falling edge, predict the next rising edge.
  task automatic step(input logic rst_n, input int up, input int dn, input int cl, input logic md);
    exp_t e;
    @(negedge clk);
    reset         = rst_n;
    w_button_up   = (up == 0);
    w_button_down = (dn == 0);
    w_button_clr  = (cl == 0);
    mode          = md;
    model_edge(rst_n, up, dn, cl);
    e.s = mk(m_cnt_s, md);
    e.w = mk(m_cnt_w, md);
    exp_q.push_back(e);
  endtask

  task automatic hold_for(input int n, input logic rst_n, input int up, input int dn,
                          input int cl, input logic md);
    for (int k = 0; k < n; k++) step(rst_n, up, dn, cl, md);
  endtask

  always begin
    exp_t  e;
    resp_t a;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{cnt: count_s, led: diod_s, mx: at_max_s, mn: at_min_s};
      checks++;
      if (a !== e.s) begin
        errors++;
        $display("FAIL sat t=%0t count=%0d diod=%h max=%b min=%b expected count=%0d diod=%h max=%b min=%b",
                 $time, a.cnt, a.led, a.mx, a.mn, e.s.cnt, e.s.led, e.s.mx, e.s.mn);
      end
      a = '{cnt: count_w, led: diod_w, mx: at_max_w, mn: at_min_w};
      checks++;
      if (a !== e.w) begin
        errors++;
        $display("FAIL wrap t=%0t count=%0d diod=%h max=%b min=%b expected count=%0d diod=%h max=%b min=%b",
                 $time, a.cnt, a.led, a.mx, a.mn, e.w.cnt, e.w.led, e.w.mx, e.w.mn);
      end
    end
  end

  initial begin
    int   up, dn, cl, len;
    logic md, rn;
    reset = 1'b0; w_button_up = 1'b1; w_button_down = 1'b1; w_button_clr = 1'b1; mode = 1'b0;
    model_edge(1'b0, 0, 0, 0);

    hold_for(3, 1'b0, 0, 0, 0, 1'b0);
    hold_for(4, 1'b1, 0, 0, 0, 1'b1);
    hold_for(10, 1'b1, 1, 0, 0, 1'b0);   // single clean press
    hold_for(12, 1'b1, 0, 0, 0, 1'b0);
    hold_for(3, 1'b1, 1, 0, 0, 1'b0);    // short glitch, ignored
    hold_for(12, 1'b1, 0, 0, 0, 1'b0);
    for (int p = 0; p < 9; p++) begin    // climb to the top and past it
      hold_for(8, 1'b1, 1, 0, 0, p[0]);
      hold_for(8, 1'b1, 0, 0, 0, p[0]);
    end
    hold_for(8, 1'b1, 0, 0, 1, 1'b0);    // clear
    hold_for(10, 1'b1, 0, 0, 0, 1'b0);
    hold_for(8, 1'b1, 0, 1, 0, 1'b0);    // down from zero
    hold_for(12, 1'b1, 0, 0, 0, 1'b1);
    hold_for(8, 1'b1, 0, 0, 1, 1'b0);
    hold_for(10, 1'b1, 0, 0, 0, 1'b0);
    hold_for(40, 1'b1, 1, 0, 0, 1'b0);   // auto-repeat
    hold_for(20, 1'b1, 0, 0, 0, 1'b0);
    hold_for(10, 1'b1, 1, 1, 0, 1'b0);   // up and down together
    hold_for(10, 1'b1, 0, 0, 0, 1'b1);
    hold_for(10, 1'b1, 1, 0, 1, 1'b0);   // clear beats up
    hold_for(10, 1'b1, 0, 0, 0, 1'b0);
    hold_for(40, 1'b1, 0, 0, 1, 1'b0);   // clear never repeats
    hold_for(10, 1'b1, 0, 0, 0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      hold_for(8, 1'b1, 1, 0, 0, 1'b0);
      hold_for(8, 1'b1, 0, 0, 0, 1'b0);
    end
    hold_for(3, 1'b1, 0, 0, 0, 1'b0);    // count 5 in both display modes
    hold_for(3, 1'b1, 0, 0, 0, 1'b1);
    hold_for(3, 1'b1, 0, 0, 0, 1'b0);
    hold_for(30, 1'b1, 1, 0, 0, 1'b0);   // reset in the middle of a repeat
    hold_for(2, 1'b0, 1, 0, 0, 1'b0);
    hold_for(30, 1'b1, 1, 0, 0, 1'b0);
    hold_for(12, 1'b1, 0, 0, 0, 1'b0);

    for (int seg = 0; seg < 300; seg++) begin
      up  = ($urandom_range(0, 2) == 0);
      dn  = ($urandom_range(0, 3) == 0);
      cl  = ($urandom_range(0, 9) == 0);
      md  = 1'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 49) != 0);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 45));
      hold_for(len, rn, up, dn, cl, md);
    end
    hold_for(12, 1'b1, 0, 0, 0, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
